input_layer_rd_sched: RTL and testbench

Read-channel scheduler that shares one AXI4 master read port between the four input-layer fetch engines feeding the 3x3 convolution streams. Each engine posts burst-sized read requests (start address only); the block arbitrates round-robin, issues fixed-length INCR bursts on AR, caps the number of outstanding bursts, and routes returning R beats to the owning engine by ARID. It sits between the input-layer stream logic and the DDR3 AXI interconnect; the write channels are not touched.

---
 rtl/input_layer_rd_sched_pkg.sv | 22 ++
 rtl/input_layer_rd_sched_rr_arbiter4.sv | 39 +++
 rtl/input_layer_rd_sched.sv | 186 ++++++++++++++++++
 tb/tb_input_layer_rd_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_layer_rd_sched_pkg.sv
// Shared constants and types for the input-layer AXI read scheduler.
// Holds the AXI burst encoding, engine count, outstanding-counter width,
// the scheduler FSM state enum and a one-hot helper.
package input_layer_rd_sched_pkg;

  localparam int unsigned NUM_ENG   = 4;
  localparam int unsigned ENG_IDX_W = 2;
  localparam int unsigned OUTST_W   = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ADDR = 1'b1
  } rd_state_e;

  // One-hot engine select from a 2-bit engine index.
  function automatic logic [NUM_ENG-1:0] eng_onehot(input logic [ENG_IDX_W-1:0] idx);
    eng_onehot = NUM_ENG'(1) << idx;
  endfunction

endpackage

// File: rtl/input_layer_rd_sched_rr_arbiter4.sv
// Four-way round-robin arbiter.
// Grants the first requester at or after ptr_i, wrapping 3 -> 0.
// Ports:
//   req_i      per-engine request
//   ptr_i      highest-priority engine index
//   gnt_o      one-hot grant (zero when no request)
//   gnt_idx_o  index of the granted engine
//   any_o      at least one request present
module input_layer_rd_sched_rr_arbiter4
  import input_layer_rd_sched_pkg::*;
(
  input  logic [NUM_ENG-1:0]   req_i,
  input  logic [ENG_IDX_W-1:0] ptr_i,
  output logic [NUM_ENG-1:0]   gnt_o,
  output logic [ENG_IDX_W-1:0] gnt_idx_o,
  output logic                 any_o
);

  logic [ENG_IDX_W-1:0] idx_c;

  // Priority scan starting from the pointer; 2-bit index wraps naturally.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = ptr_i;
    any_o     = 1'b0;
    idx_c     = '0;
    for (int unsigned k = 0; k < NUM_ENG; k++) begin
      idx_c = ptr_i + ENG_IDX_W'(k);
      if (!any_o && req_i[idx_c]) begin
        any_o     = 1'b1;
        gnt_idx_o = idx_c;
      end
    end
    if (any_o) begin
      gnt_o = eng_onehot(gnt_idx_o);
    end
  end

endmodule

// File: rtl/input_layer_rd_sched.sv
// AXI4 read-channel scheduler for the four input-layer fetch engines.
// Arbitrates burst requests round-robin, issues fixed-length INCR bursts on
// AR, caps outstanding bursts, and routes R beats back by ARID.
// Optional build macro: INPUT_LAYER_RD_ALIGN_CHECK_EN -- misaligned requests
// are accepted but dropped (no AR) and flag rd_err for the engine.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   req_valid/addr/ready per-engine burst request (ready is one-hot, comb)
//   M_axi_ar*            AXI read address channel (master)
//   M_axi_r*             AXI read data channel (master)
//   rd_data/valid/last   beat passthrough to engines, rd_valid one-hot by rid
//   rd_ready             per-engine data ready
//   rd_err               sticky per-engine error flags
//   outstanding          issued-but-incomplete burst count
module input_layer_rd_sched
  import input_layer_rd_sched_pkg::*;
#(
  parameter int unsigned C_S_AXI_ID_WIDTH   = 3,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 64,
  parameter int unsigned C_S_AXI_BURST_LEN  = 8,
  parameter int unsigned MAX_OUTSTANDING    = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_ENG-1:0]                    req_valid,
  input  logic [NUM_ENG*C_S_AXI_ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_ENG-1:0]                    req_ready,
  output logic [C_S_AXI_ID_WIDTH-1:0]           M_axi_arid,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]         M_axi_araddr,
  output logic [7:0]                            M_axi_arlen,
  output logic [2:0]                            M_axi_arsize,
  output logic [1:0]                            M_axi_arburst,
  output logic                                  M_axi_arvalid,
  input  logic                                  M_axi_arready,
  input  logic [C_S_AXI_ID_WIDTH-1:0]           M_axi_rid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]         M_axi_rdata,
  input  logic [1:0]                            M_axi_rresp,
  input  logic                                  M_axi_rlast,
  input  logic                                  M_axi_rvalid,
  output logic                                  M_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]         rd_data,
  output logic [NUM_ENG-1:0]                    rd_valid,
  output logic                                  rd_last,
  input  logic [NUM_ENG-1:0]                    rd_ready,
  output logic [NUM_ENG-1:0]                    rd_err,
  output logic [OUTST_W-1:0]                    outstanding
);

  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned IW = C_S_AXI_ID_WIDTH;

  rd_state_e              state_q, state_d;
  logic [ENG_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ENG_IDX_W-1:0]   gnt_q, gnt_d;
  logic [AW-1:0]          araddr_q, araddr_d;
  logic [OUTST_W-1:0]     outstanding_q, outstanding_d;
  logic [NUM_ENG-1:0]     rd_err_q, rd_err_d;

  logic [NUM_ENG-1:0]     arb_gnt_c;
  logic [ENG_IDX_W-1:0]   arb_idx_c;
  logic                   arb_any_c;
  logic [AW-1:0]          sel_addr_c;
  logic                   ar_hs_c;
  logic [NUM_ENG-1:0]     drop_err_c;
  logic                   rid_ok_c;
  logic [ENG_IDX_W-1:0]   rid_lo_c;
  logic                   r_hs_c;
  logic                   dec_c;
  logic [NUM_ENG-1:0]     err_set_c;
  logic                   unused_rresp0;

  input_layer_rd_sched_rr_arbiter4 u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt_c),
    .gnt_idx_o (arb_idx_c),
    .any_o     (arb_any_c)
  );

  assign sel_addr_c = req_addr[arb_idx_c*AW +: AW];

`ifdef INPUT_LAYER_RD_ALIGN_CHECK_EN
  localparam int unsigned ALIGN_BYTES = C_S_AXI_BURST_LEN * C_S_AXI_DATA_WIDTH / 8;
  logic misaligned_c;
  assign misaligned_c = (sel_addr_c % AW'(ALIGN_BYTES)) != '0;
`endif

  // Scheduler FSM: grant in IDLE, hold AR in ADDR until accepted.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    araddr_d   = araddr_q;
    req_ready  = '0;
    drop_err_c = '0;
    ar_hs_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any_c && (outstanding_q < OUTST_W'(MAX_OUTSTANDING))) begin
          req_ready = arb_gnt_c;
`ifdef INPUT_LAYER_RD_ALIGN_CHECK_EN
          // Misaligned request is consumed without an AR; move the pointer on
          // so the offending engine cannot monopolise the grant.
          if (misaligned_c) begin
            drop_err_c = arb_gnt_c;
            rr_ptr_d   = arb_idx_c + ENG_IDX_W'(1);
          end else begin
            gnt_d    = arb_idx_c;
            araddr_d = sel_addr_c;
            state_d  = ST_ADDR;
          end
`else
          gnt_d    = arb_idx_c;
          araddr_d = sel_addr_c;
          state_d  = ST_ADDR;
`endif
        end
      end
      ST_ADDR: begin
        if (M_axi_arready) begin
          ar_hs_c  = 1'b1;
          rr_ptr_d = gnt_q + ENG_IDX_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // R routing: ids outside the engine range are consumed and dropped.
  assign rid_ok_c = {1'b0, M_axi_rid} < (IW + 1)'(NUM_ENG);
  assign rid_lo_c = M_axi_rid[ENG_IDX_W-1:0];

  always_comb begin
    rd_valid = '0;
    if (M_axi_rvalid && rid_ok_c) begin
      rd_valid = eng_onehot(rid_lo_c);
    end
  end

  assign M_axi_rready  = rid_ok_c ? rd_ready[rid_lo_c] : 1'b1;
  assign r_hs_c        = M_axi_rvalid && M_axi_rready && rid_ok_c;
  assign rd_data       = M_axi_rdata;
  assign rd_last       = M_axi_rlast;
  assign unused_rresp0 = M_axi_rresp[0];

  // Outstanding count and sticky error flags.
  always_comb begin
    dec_c     = r_hs_c && M_axi_rlast && (outstanding_q != '0);
    err_set_c = drop_err_c;
    if (r_hs_c && (M_axi_rresp[1] || (M_axi_rlast && (outstanding_q == '0)))) begin
      err_set_c = err_set_c | eng_onehot(rid_lo_c);
    end
    outstanding_d = outstanding_q + OUTST_W'(ar_hs_c) - OUTST_W'(dec_c);
    rd_err_d      = rd_err_q | err_set_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      gnt_q         <= '0;
      araddr_q      <= '0;
      outstanding_q <= '0;
      rd_err_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_q         <= gnt_d;
      araddr_q      <= araddr_d;
      outstanding_q <= outstanding_d;
      rd_err_q      <= rd_err_d;
    end
  end

  assign M_axi_arvalid = (state_q == ST_ADDR);
  assign M_axi_arid    = IW'(gnt_q);
  assign M_axi_araddr  = araddr_q;
  assign M_axi_arlen   = 8'(C_S_AXI_BURST_LEN - 1);
  assign M_axi_arsize  = 3'($clog2(C_S_AXI_DATA_WIDTH / 8));
  assign M_axi_arburst = AXI_BURST_INCR;
  assign rd_err        = rd_err_q;
  assign outstanding   = outstanding_q;

endmodule

// File: tb/tb_input_layer_rd_sched.sv
// Randomized scoreboard bench for input_layer_rd_sched.
module tb_input_layer_rd_sched;

  localparam int unsigned IDW  = 3;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 64;
  localparam int unsigned BLEN = 8;
  localparam int unsigned MAXO = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req_valid;
  logic [4*AW-1:0] req_addr;
  logic [3:0]      req_ready;
  logic [IDW-1:0]  M_axi_arid;
  logic [AW-1:0]   M_axi_araddr;
  logic [7:0]      M_axi_arlen;
  logic [2:0]      M_axi_arsize;
  logic [1:0]      M_axi_arburst;
  logic            M_axi_arvalid;
  logic            M_axi_arready;
  logic [IDW-1:0]  M_axi_rid;
  logic [DW-1:0]   M_axi_rdata;
  logic [1:0]      M_axi_rresp;
  logic            M_axi_rlast;
  logic            M_axi_rvalid;
  logic            M_axi_rready;
  logic [DW-1:0]   rd_data;
  logic [3:0]      rd_valid;
  logic            rd_last;
  logic [3:0]      rd_ready;
  logic [3:0]      rd_err;
  logic [3:0]      outstanding;

  input_layer_rd_sched dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .M_axi_arid(M_axi_arid), .M_axi_araddr(M_axi_araddr), .M_axi_arlen(M_axi_arlen),
    .M_axi_arsize(M_axi_arsize), .M_axi_arburst(M_axi_arburst),
    .M_axi_arvalid(M_axi_arvalid), .M_axi_arready(M_axi_arready),
    .M_axi_rid(M_axi_rid), .M_axi_rdata(M_axi_rdata), .M_axi_rresp(M_axi_rresp),
    .M_axi_rlast(M_axi_rlast), .M_axi_rvalid(M_axi_rvalid), .M_axi_rready(M_axi_rready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .rd_err(rd_err), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus knobs ----------------
  int          req_left[4];
  int          req_prob, ar_prob, r_prob, rdy_prob, err_prob;
  bit          use_fixed;
  logic [31:0] fixed_addr;
  bit          inject_bad, inject_spur;
  bit          drv_en;

  // ---------------- driver: engines + AXI slave ----------------
  int  slave_q[$];
  int  beat;
  bit  cur_special;

  initial begin : driver
    logic [3:0]     req_fire;
    bit             ar_fire, r_fire;
    logic [IDW-1:0] ar_id;
    forever begin
      @(negedge clk);
      req_fire = req_valid & req_ready;
      ar_fire  = M_axi_arvalid && M_axi_arready;
      ar_id    = M_axi_arid;
      r_fire   = M_axi_rvalid && M_axi_rready;
      @(posedge clk);
      #1;
      if (drv_en) begin
        for (int i = 0; i < 4; i++) begin
          if (req_fire[i]) begin
            req_valid[i] = 1'b0;
            if (req_left[i] > 0) req_left[i]--;
          end
          if (!req_valid[i] && req_left[i] > 0 && $urandom_range(99) < req_prob) begin
            req_valid[i] = 1'b1;
            req_addr[i*AW +: AW] = use_fixed ? fixed_addr : ($urandom() & 32'hFFFF_FFC0);
          end
        end
        if (ar_fire) slave_q.push_back(int'(ar_id));
        M_axi_arready = ($urandom_range(99) < ar_prob);
        if (r_fire) begin
          if (cur_special) cur_special = 1'b0;
          else begin
            beat++;
            if (beat == BLEN) begin
              beat = 0;
              void'(slave_q.pop_front());
            end
          end
          M_axi_rvalid = 1'b0;
        end
        if (!M_axi_rvalid) begin
          if (inject_bad) begin
            inject_bad = 1'b0; cur_special = 1'b1;
            M_axi_rvalid = 1'b1; M_axi_rid = IDW'(5); M_axi_rlast = 1'b1;
            M_axi_rresp = 2'b00; M_axi_rdata = {$urandom(), $urandom()};
          end else if (inject_spur && slave_q.size() == 0) begin
            inject_spur = 1'b0; cur_special = 1'b1;
            M_axi_rvalid = 1'b1; M_axi_rid = IDW'(3); M_axi_rlast = 1'b1;
            M_axi_rresp = 2'b00; M_axi_rdata = {$urandom(), $urandom()};
          end else if (slave_q.size() > 0 && $urandom_range(99) < r_prob) begin
            M_axi_rvalid = 1'b1;
            M_axi_rid    = IDW'(slave_q[0]);
            M_axi_rlast  = (beat == BLEN - 1);
            M_axi_rresp  = ($urandom_range(99) < err_prob) ? 2'b10 : 2'b00;
            M_axi_rdata  = {$urandom(), $urandom()};
          end
        end
        for (int i = 0; i < 4; i++) rd_ready[i] = ($urandom_range(99) < rdy_prob);
      end
    end
  end

  // ---------------- reference model + monitor ----------------
  typedef struct {
    int          id;
    logic [31:0] addr;
  } ar_exp_t;

  ar_exp_t    ar_q[$];
  bit         m_busy;
  int         m_ptr;
  int         m_cnt;
  logic [3:0] m_err;

`ifdef INPUT_LAYER_RD_ALIGN_CHECK_EN
  function automatic bit aligned(input logic [31:0] a);
    return (a % (BLEN * DW / 8)) == 0;
  endfunction
`endif

  always @(negedge clk) begin : monitor
    logic [3:0] exp_ready, exp_rv;
    logic       exp_rr;
    int         g, cnt_old, inc, dec, rid;
    ar_exp_t    e;
    if (reset) begin
      ar_q.delete();
      m_busy = 1'b0; m_ptr = 0; m_cnt = 0; m_err = '0;
    end else begin
      // Expected grant: first requester at or after the pointer.
      exp_ready = '0;
      g = 0;
      if (!m_busy && m_cnt < MAXO && req_valid != 4'b0) begin
        for (int k = 0; k < 4; k++) begin
          g = (m_ptr + k) % 4;
          if (req_valid[g]) break;
        end
        exp_ready[g] = 1'b1;
      end
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      chk("arvalid", 64'(M_axi_arvalid), 64'(m_busy));
      chk("outstanding", 64'(outstanding), 64'(m_cnt));
      chk("rd_err", 64'(rd_err), 64'(m_err));

      rid    = int'(M_axi_rid);
      exp_rr = 1'b0;
      if (M_axi_rvalid) begin
        if (rid < 4) begin
          exp_rv = 4'(1 << rid);
          exp_rr = rd_ready[rid];
        end else begin
          exp_rv = 4'b0;
          exp_rr = 1'b1;
        end
        chk("rd_valid", 64'(rd_valid), 64'(exp_rv));
        chk("rready", 64'(M_axi_rready), 64'(exp_rr));
        chk("rd_data", rd_data, M_axi_rdata);
        chk("rd_last", 64'(rd_last), 64'(M_axi_rlast));
      end else begin
        chk("rd_valid_idle", 64'(rd_valid), 64'(0));
      end

      cnt_old = m_cnt;
      inc = 0;
      dec = 0;
      if (m_busy) begin
        if (ar_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL ar_scoreboard: arvalid with empty expectation queue");
        end else begin
          e = ar_q[0];
          chk("arid", 64'(M_axi_arid), 64'(e.id));
          chk("araddr", 64'(M_axi_araddr), 64'(e.addr));
          chk("arlen", 64'(M_axi_arlen), 64'(BLEN - 1));
          chk("arsize", 64'(M_axi_arsize), 64'(3));
          chk("arburst", 64'(M_axi_arburst), 64'(1));
          if (M_axi_arready) begin
            void'(ar_q.pop_front());
            m_ptr  = (e.id + 1) % 4;
            m_busy = 1'b0;
            inc    = 1;
          end
        end
      end
      if (M_axi_rvalid && exp_rr && rid < 4) begin
        if (M_axi_rresp[1]) m_err[rid] = 1'b1;
        if (M_axi_rlast) begin
          if (cnt_old == 0) m_err[rid] = 1'b1;
          else dec = 1;
        end
      end
      m_cnt = cnt_old + inc - dec;

      if (exp_ready != 4'b0) begin
        e.id   = g;
        e.addr = req_addr[g*AW +: AW];
`ifdef INPUT_LAYER_RD_ALIGN_CHECK_EN
        if (!aligned(e.addr)) begin
          m_err[g] = 1'b1;
          m_ptr    = (g + 1) % 4;
        end else begin
          ar_q.push_back(e);
          m_busy = 1'b1;
        end
`else
        ar_q.push_back(e);
        m_busy = 1'b1;
`endif
      end
    end
  end

  // ---------------- phase sequencing ----------------
  initial begin
    req_valid = '0; req_addr = '0; rd_ready = '0;
    M_axi_arready = 1'b0; M_axi_rvalid = 1'b0; M_axi_rid = '0; M_axi_rdata = '0;
    M_axi_rresp = 2'b00; M_axi_rlast = 1'b0;
    for (int i = 0; i < 4; i++) req_left[i] = 0;
    req_prob = 0; ar_prob = 0; r_prob = 0; rdy_prob = 0; err_prob = 0;
    use_fixed = 1'b0; fixed_addr = '0; inject_bad = 1'b0; inject_spur = 1'b0;
    drv_en = 1'b0; beat = 0; cur_special = 1'b0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_arvalid", 64'(M_axi_arvalid), 64'(0));
    chk("rst_araddr", 64'(M_axi_araddr), 64'(0));
    chk("rst_arid", 64'(M_axi_arid), 64'(0));
    chk("rst_outstanding", 64'(outstanding), 64'(0));
    chk("rst_rd_err", 64'(rd_err), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    drv_en = 1'b1;

    // Single request from engine 2 at 0x1000, full-speed slave.
    use_fixed = 1'b1; fixed_addr = 32'h0000_1000;
    req_left[2] = 1; req_prob = 100; ar_prob = 100; r_prob = 100; rdy_prob = 100;
    repeat (40) @(posedge clk);

    // All engines requesting continuously, slow AR ready.
    use_fixed = 1'b0;
    for (int i = 0; i < 4; i++) req_left[i] = 40;
    ar_prob = 50;
    repeat (300) @(posedge clk);

    // No R traffic: outstanding cap must block further grants.
    for (int i = 0; i < 4; i++) req_left[i] = 3;
    ar_prob = 100; r_prob = 0;
    repeat (60) @(posedge clk);
    r_prob = 100;
    repeat (200) @(posedge clk);

    // Fully random traffic with occasional error responses.
    for (int i = 0; i < 4; i++) req_left[i] = 150;
    req_prob = 30; ar_prob = 60; r_prob = 70; rdy_prob = 70; err_prob = 2;
    repeat (3000) @(posedge clk);

    // Out-of-range rid beat, then drain and a spurious rlast with count 0.
    inject_bad = 1'b1;
    repeat (20) @(posedge clk);
    for (int i = 0; i < 4; i++) req_left[i] = 0;
    ar_prob = 100; r_prob = 100; rdy_prob = 100; err_prob = 0;
    repeat (600) @(posedge clk);
    inject_spur = 1'b1;
    repeat (30) @(posedge clk);

    @(negedge clk);
    chk("drain_outstanding", 64'(outstanding), 64'(0));
    chk("drain_ar_queue", 64'(ar_q.size()), 64'(0));
    chk("spurious_rlast_err", 64'(rd_err[3]), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
